// File: rtl/issue_stage.sv
// Issue stage: instruction FIFO, 16x16 register file with writeback bypass,
// RAW scoreboard and multiplier-wait FSM feeding registered operands to the ALU.
module issue_stage #(
  parameter int FIFO_DEPTH = 2,
  parameter int MUL_LAT    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [15:0] fetch_instr,
  output logic        fetch_ready,
  input  logic [1:0]  alu_status,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic [15:0] instr,
  output logic [15:0] rs1_data,
  output logic [15:0] rs2_data,
  output logic        issue_valid,
  output logic        err_illegal,
  output logic [0:0]  dbg_state
);

  // Fetch handshake: an entry is accepted on any edge where fetch_valid && fetch_ready.
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int MC_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [MC_W-1:0]  MC_INIT = MC_W'(MUL_LAT - 1);

  localparam logic [0:0] S_ISSUE    = 1'b0;
  localparam logic [0:0] S_MUL_WAIT = 1'b1;

  logic [15:0]      fifo_q [FIFO_DEPTH];
  logic [15:0]      fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      rf_q [16];
  logic [15:0]      rf_d [16];
  logic [15:0]      pending_q, pending_d;
  logic [0:0]       state_q, state_d;
  logic [MC_W-1:0]  mcnt_q, mcnt_d;
  logic [15:0]      instr_q, instr_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic             valid_q, valid_d, err_q, err_d;

  logic [15:0] head, wb_clr, pend_eff, rs1_val, rs2_val;
  logic [3:0]  op, rd, rs1_addr, rs2_addr;
  logic        is_rtype, is_illegal, hazard, gate, do_issue, do_drop, push, pop;

  always_comb begin
    head       = fifo_q[rd_ptr_q];
    op         = head[15:12];
    rd         = head[11:8];
    is_rtype   = (op <= 4'd5);
    is_illegal = (op >= 4'd11);
    rs1_addr   = is_rtype ? head[7:4] : head[3:0];
    rs2_addr   = head[3:0];
    // A writeback landing this cycle already releases its register for the head.
    wb_clr     = wb_en ? (16'h0001 << wb_addr) : 16'h0000;
    pend_eff   = pending_q & ~wb_clr;
    hazard     = pend_eff[rs1_addr] || (is_rtype && pend_eff[rs2_addr]);
    gate       = (count_q != '0) && (state_q == S_ISSUE) && (alu_status == 2'b00);
    do_issue   = gate && !is_illegal && !hazard;
    do_drop    = gate && is_illegal;
    pop        = do_issue || do_drop;
    push       = fetch_valid && fetch_ready;
  end

  always_comb begin
    rs1_val = 16'h0000;
    rs2_val = 16'h0000;
    if (rs1_addr != 4'd0)
      rs1_val = (wb_en && wb_addr == rs1_addr) ? wb_data : rf_q[rs1_addr];
    if (is_rtype && rs2_addr != 4'd0)
      rs2_val = (wb_en && wb_addr == rs2_addr) ? wb_data : rf_q[rs2_addr];
  end

  assign fetch_ready = (count_q < DEPTH_C);

  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = fetch_instr;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_en && wb_addr != 4'd0) rf_d[wb_addr] = wb_data;
    // Set after clear so an issue claiming the same rd keeps it pending.
    pending_d = pending_q & ~wb_clr;
    if (do_issue && rd != 4'd0) pending_d[rd] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      S_ISSUE: begin
        if (do_issue && op == 4'd5) begin
          state_d = S_MUL_WAIT;
          mcnt_d  = MC_INIT;
        end
      end
      S_MUL_WAIT: begin
        if (mcnt_q == '0) begin
          if (alu_status == 2'b00) state_d = S_ISSUE;
        end else begin
          mcnt_d = mcnt_q - 1'b1;
        end
      end
      default: state_d = S_ISSUE;
    endcase
  end

  always_comb begin
    instr_d = 16'h0000;
    rs1_d   = 16'h0000;
    rs2_d   = 16'h0000;
    valid_d = 1'b0;
    err_d   = err_q || do_drop;
    if (do_issue) begin
      instr_d = head;
      rs1_d   = rs1_val;
      rs2_d   = rs2_val;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 16'h0000;
      for (int i = 0; i < 16; i++) rf_q[i] <= 16'h0000;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= 16'h0000;
      state_q   <= S_ISSUE;
      mcnt_q    <= '0;
      instr_q   <= 16'h0000;
      rs1_q     <= 16'h0000;
      rs2_q     <= 16'h0000;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      rf_q      <= rf_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      mcnt_q    <= mcnt_d;
      instr_q   <= instr_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign instr       = instr_q;
  assign rs1_data    = rs1_q;
  assign rs2_data    = rs2_q;
  assign issue_valid = valid_q;
  assign err_illegal = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: hand-computed outputs checked 1 time unit
// after each rising edge; inputs change at the same point.
module tb_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [15:0] fetch_instr;
  logic        fetch_ready;
  logic [1:0]  alu_status;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [15:0] instr;
  logic [15:0] rs1_data;
  logic [15:0] rs2_data;
  logic        issue_valid;
  logic        err_illegal;
  logic [0:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  issue_stage #(.FIFO_DEPTH(2), .MUL_LAT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_ready (fetch_ready),
    .alu_status  (alu_status),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .instr       (instr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .issue_valid (issue_valid),
    .err_illegal (err_illegal),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic check_issue(input string tag, input logic v, input logic [15:0] i,
                             input logic [15:0] a, input logic [15:0] b);
    check({tag, "_valid"}, 16'(issue_valid), 16'(v));
    check({tag, "_instr"}, instr, i);
    check({tag, "_rs1"}, rs1_data, a);
    check({tag, "_rs2"}, rs2_data, b);
  endtask

  // Driver tasks
  task automatic wb(input logic [3:0] a, input logic [15:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic push(input logic [15:0] ins);
    fetch_valid = 1'b1; fetch_instr = ins;
    tick();
    fetch_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_instr = 16'h0000;
    alu_status = 2'b00; wb_en = 1'b0; wb_addr = 4'd0; wb_data = 16'h0000;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    check_issue("rst", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    check("rst_err", 16'(err_illegal), 16'h0);
    check("rst_ready", 16'(fetch_ready), 16'h1);
    check("rst_state", 16'(dbg_state), 16'h0);

    // 1: ADD r1,r2,r3 with r2=5, r3=7
    wb(4'd2, 16'h0005);
    wb(4'd3, 16'h0007);
    push(16'h0123);
    check("t1_lat", 16'(issue_valid), 16'h0);
    tick();
    check_issue("t1", 1'b1, 16'h0123, 16'h0005, 16'h0007);
    wb(4'd1, 16'h0011);
    check_issue("t1_bub", 1'b0, 16'h0000, 16'h0000, 16'h0000);

    // 2: MUL r3,r1,r2 then ADD r4,r3,r0 held through MUL_WAIT
    fetch_valid = 1'b1; fetch_instr = 16'h5312;
    tick();
    fetch_instr = 16'h0430;
    tick();
    fetch_valid = 1'b0;
    check_issue("t2_mul", 1'b1, 16'h5312, 16'h0011, 16'h0005);
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'h0033;
    tick();
    wb_en = 1'b0;
    check("t2_w1", 16'(issue_valid), 16'h0);
    check("t2_st1", 16'(dbg_state), 16'h1);
    tick();
    check("t2_w2", 16'(issue_valid), 16'h0);
    alu_status = 2'b01;
    tick();
    check("t2_w3", 16'(issue_valid), 16'h0);
    check("t2_st3", 16'(dbg_state), 16'h1);
    alu_status = 2'b00;
    tick();
    check("t2_w4", 16'(issue_valid), 16'h0);
    check("t2_st4", 16'(dbg_state), 16'h0);
    tick();
    check_issue("t2_add", 1'b1, 16'h0430, 16'h0033, 16'h0000);
    wb(4'd4, 16'h0044);

    // 3: RAW hold on r1, released by writeback with bypass
    fetch_valid = 1'b1; fetch_instr = 16'h0123;
    tick();
    fetch_instr = 16'h0415;
    tick();
    fetch_valid = 1'b0;
    check_issue("t3_a", 1'b1, 16'h0123, 16'h0005, 16'h0033);
    tick();
    check("t3_h1", 16'(issue_valid), 16'h0);
    tick();
    check("t3_h2", 16'(issue_valid), 16'h0);
    wb_en = 1'b1; wb_addr = 4'd1; wb_data = 16'h00AA;
    tick();
    wb_en = 1'b0;
    check_issue("t3_byp", 1'b1, 16'h0415, 16'h00AA, 16'h0000);
    wb(4'd4, 16'h0044);

    // 4: fetch_valid held, FIFO fills behind a pending source
    fetch_valid = 1'b1; fetch_instr = 16'h0600;
    tick();
    fetch_instr = 16'h0760;
    tick();
    check("t4_i0", instr, 16'h0600);
    check("t4_rdy1", 16'(fetch_ready), 16'h1);
    fetch_instr = 16'h0860;
    tick();
    check("t4_rdy2", 16'(fetch_ready), 16'h0);
    check("t4_hold", 16'(issue_valid), 16'h0);
    tick();
    check("t4_rdy3", 16'(fetch_ready), 16'h0);
    wb_en = 1'b1; wb_addr = 4'd6; wb_data = 16'h0066;
    tick();
    wb_en = 1'b0;
    check_issue("t4_rel", 1'b1, 16'h0760, 16'h0066, 16'h0000);
    check("t4_rdy4", 16'(fetch_ready), 16'h1);
    tick();
    fetch_valid = 1'b0;
    check_issue("t4_pp", 1'b1, 16'h0860, 16'h0066, 16'h0000);
    check("t4_rdy5", 16'(fetch_ready), 16'h1);
    tick();
    check_issue("t4_last", 1'b1, 16'h0860, 16'h0066, 16'h0000);
    tick();
    check("t4_empty", 16'(issue_valid), 16'h0);
    check("t4_rdy6", 16'(fetch_ready), 16'h1);

    // 5: illegal opcode dropped, sticky error, next entry still issues
    push(16'hB000);
    tick();
    check_issue("t5_drop", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    check("t5_err", 16'(err_illegal), 16'h1);
    push(16'h6122);
    tick();
    check_issue("t5_itype", 1'b1, 16'h6122, 16'h0005, 16'h0000);
    wb(4'd1, 16'h0011);
    check("t5_sticky", 16'(err_illegal), 16'h1);

    // 6: reset mid MUL_WAIT with FIFO full
    fetch_valid = 1'b1; fetch_instr = 16'h5312;
    tick();
    fetch_instr = 16'h0430;
    tick();
    check("t6_mul", 16'(issue_valid), 16'h1);
    fetch_instr = 16'h0123;
    tick();
    fetch_valid = 1'b0;
    check("t6_full", 16'(fetch_ready), 16'h0);
    check("t6_st", 16'(dbg_state), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_issue("t6_rst", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    check("t6_rdy", 16'(fetch_ready), 16'h1);
    check("t6_err", 16'(err_illegal), 16'h0);
    check("t6_state", 16'(dbg_state), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(16'h0430);
    tick();
    check_issue("t6_clr", 1'b1, 16'h0430, 16'h0000, 16'h0000);

    // r0 reads zero even under a same-cycle writeback to r0
    push(16'h0100);
    wb_en = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF;
    tick();
    wb_en = 1'b0;
    check_issue("r0", 1'b1, 16'h0100, 16'h0000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
